// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: scan classification,
// committed-state encoding and matrix geometry.
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam logic [3:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } scan_res_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } key_state_t;

    function automatic scan_res_t classify_scan(input logic [15:0] keys);
        logic [4:0] n;
        scan_res_t  res;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, keys[i]};
        end
        if (n == 5'd0)      res = RES_NONE;
        else if (n == 5'd1) res = RES_KEY;
        else                res = RES_MULTI;
        return res;
    endfunction

    // Lowest closed key; only meaningful when exactly one key is closed.
    function automatic logic [3:0] encode_scan(input logic [15:0] keys);
        logic [3:0] code;
        code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (keys[i]) code = 4'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce and commit logic: tracks a candidate scan result and its repeat
// count, and drives the IDLE/HELD committed state with press/release strobes.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_res_valid,
    input  scan_res_t  i_res_kind,
    input  logic [3:0] i_res_code,
    output logic [3:0] o_code,
    output logic       o_press,
    output logic       o_release,
    output logic       o_key_down,
    output key_state_t o_state
);

    localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_SCANS);

    scan_res_t  r_cand_kind;
    logic [3:0] r_cand_code;
    logic [3:0] r_cnt;
    key_state_t r_state;
    logic [3:0] r_code;
    logic       r_press;
    logic       r_release;
    logic       r_key_down;

    logic       w_same;
    logic [3:0] w_cnt_next;
    logic       w_stable;

    always_comb begin
        w_same = (i_res_kind == r_cand_kind) &&
                 ((i_res_kind != RES_KEY) || (i_res_code == r_cand_code));
        if (i_res_kind == RES_MULTI)  w_cnt_next = 4'd0;
        else if (!w_same)             w_cnt_next = 4'd1;
        else if (r_cnt == 4'd15)      w_cnt_next = 4'd15;
        else                          w_cnt_next = r_cnt + 4'd1;
        // >= rather than == so a key held through enable-low still commits later
        w_stable = i_res_valid && (w_cnt_next >= DB_CNT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand_kind <= RES_NONE;
            r_cand_code <= '0;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
            r_code      <= '0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (i_res_valid) begin
                r_cand_kind <= i_res_kind;
                r_cand_code <= i_res_code;
                r_cnt       <= w_cnt_next;
            end
            if (!i_enable) begin
                r_state    <= ST_IDLE;
                r_key_down <= 1'b0;
            end else if (w_stable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_res_kind == RES_KEY) begin
                            r_code     <= i_res_code;
                            r_press    <= 1'b1;
                            r_key_down <= 1'b1;
                            r_state    <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (i_res_kind == RES_NONE) begin
                            r_release  <= 1'b1;
                            r_key_down <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else if (i_res_kind == RES_KEY && i_res_code != r_code) begin
                            r_code  <= i_res_code;
                            r_press <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_code     = r_code;
    assign o_press    = r_press;
    assign o_release  = r_release;
    assign o_key_down = r_key_down;
    assign o_state    = r_state;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: drives one-cold columns, synchronises and
// samples the rows, classifies each full scan and hands it to the debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_data,
    output logic       keypad_enable,
    output logic       key_down,
    output logic       key_release,
    output key_state_t dbg_state
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [15:0]      r_keys;

    logic             w_slot_end;
    logic             w_res_valid;
    logic [15:0]      w_keys;
    scan_res_t        w_res_kind;
    logic [3:0]       w_res_code;

    assign w_slot_end  = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_res_valid = w_slot_end && (r_col == 2'd3);
    assign col_out     = ~(4'b0001 << r_col);

    // Current column's bits are replaced from the synchronised rows so the
    // column-3 result includes this slot's sample.
    always_comb begin
        w_keys = r_keys;
        for (int r = 0; r < KEY_ROWS; r++) begin
            w_keys[r * KEY_COLS + int'(r_col)] = ~r_row_sync[r];
        end
        w_res_kind = classify_scan(w_keys);
        w_res_code = encode_scan(w_keys);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_col      <= '0;
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
            r_keys     <= '0;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
            if (w_slot_end) begin
                r_div  <= '0;
                r_col  <= r_col + 2'd1;
                r_keys <= w_keys;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_enable   (enable),
        .i_res_valid(w_res_valid),
        .i_res_kind (w_res_kind),
        .i_res_code (w_res_code),
        .o_code     (keypad_data),
        .o_press    (keypad_enable),
        .o_release  (key_release),
        .o_key_down (key_down),
        .o_state    (dbg_state)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (16-cycle scan); a small matrix model turns held keys into row levels.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN = 16;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] keypad_data;
    logic       keypad_enable;
    logic       key_down;
    logic       key_release;
    key_state_t dbg_state;

    logic [15:0] held_keys;

    int n_cmp;
    int n_err;
    int press_cnt;
    int rel_cnt;
    int excl_cnt;
    int kd_low_cnt;
    logic [3:0] press_code;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .row_in       (row_in),
        .col_out      (col_out),
        .keypad_data  (keypad_data),
        .keypad_enable(keypad_enable),
        .key_down     (key_down),
        .key_release  (key_release),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix: a closed key at (r,c) pulls row r low while column c is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~(|(held_keys[r*4 +: 4] & ~col_out));
        end
    end

    // strobe monitor, sampled away from the active edge
    initial begin
        press_cnt  = 0;
        rel_cnt    = 0;
        excl_cnt   = 0;
        kd_low_cnt = 0;
        press_code = '0;
    end

    always @(negedge clk) begin
        if (keypad_enable === 1'b1) begin
            press_cnt  = press_cnt + 1;
            press_code = keypad_data;
        end
        if (key_release === 1'b1) rel_cnt = rel_cnt + 1;
        if (keypad_enable === 1'b1 && key_release === 1'b1) excl_cnt = excl_cnt + 1;
        if (key_down !== 1'b1) kd_low_cnt = kd_low_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        enable    = 1'b1;
        held_keys = '0;
        wait_cycles(3);
        n_cmp++; if (col_out !== 4'b1110) begin n_err++; $display("FAIL reset_col_out: got %b expected %b", col_out, 4'b1110); end
        n_cmp++; if (keypad_data !== 4'd0) begin n_err++; $display("FAIL reset_data: got %0d expected 0", keypad_data); end
        n_cmp++; if (keypad_enable !== 1'b0) begin n_err++; $display("FAIL reset_press: got %b expected 0", keypad_enable); end
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL reset_key_down: got %b expected 0", key_down); end
        n_cmp++; if (key_release !== 1'b0) begin n_err++; $display("FAIL reset_release: got %b expected 0", key_release); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        reset = 1'b1;
        wait_cycles(4);
        n_cmp++; if (col_out !== 4'b1101) begin n_err++; $display("FAIL col_seq_1: got %b expected %b", col_out, 4'b1101); end
        wait_cycles(4);
        n_cmp++; if (col_out !== 4'b1011) begin n_err++; $display("FAIL col_seq_2: got %b expected %b", col_out, 4'b1011); end
        wait_cycles(8);
        n_cmp++; if (col_out !== 4'b1110) begin n_err++; $display("FAIL col_seq_wrap: got %b expected %b", col_out, 4'b1110); end
    endtask

    task automatic test_clean_press();
        int p0, r0;
        p0 = press_cnt; r0 = rel_cnt;
        held_keys = 16'h0040;
        wait_cycles(24);
        n_cmp++; if (press_cnt - p0 !== 0) begin n_err++; $display("FAIL clean_early: got %0d presses expected 0", press_cnt - p0); end
        wait_cycles(10*SCAN - 24);
        n_cmp++; if (press_cnt - p0 !== 1) begin n_err++; $display("FAIL clean_press_cnt: got %0d expected 1", press_cnt - p0); end
        n_cmp++; if (press_code !== 4'd6) begin n_err++; $display("FAIL clean_code: got %0d expected 6", press_code); end
        n_cmp++; if (key_down !== 1'b1) begin n_err++; $display("FAIL clean_key_down: got %b expected 1", key_down); end
        held_keys = '0;
        wait_cycles(6*SCAN);
        n_cmp++; if (rel_cnt - r0 !== 1) begin n_err++; $display("FAIL clean_release_cnt: got %0d expected 1", rel_cnt - r0); end
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL clean_key_up: got %b expected 0", key_down); end
        n_cmp++; if (keypad_data !== 4'd6) begin n_err++; $display("FAIL clean_data_hold: got %0d expected 6", keypad_data); end
        n_cmp++; if (press_cnt - p0 !== 1) begin n_err++; $display("FAIL clean_no_extra: got %0d expected 1", press_cnt - p0); end
    endtask

    task automatic test_bounce();
        int p0, r0;
        p0 = press_cnt; r0 = rel_cnt;
        for (int s = 0; s < 8; s++) begin
            held_keys = (s % 2 == 0) ? 16'h0200 : 16'h0000;
            wait_cycles(SCAN);
        end
        n_cmp++; if (press_cnt - p0 !== 0) begin n_err++; $display("FAIL bounce_press: got %0d expected 0", press_cnt - p0); end
        n_cmp++; if (rel_cnt - r0 !== 0) begin n_err++; $display("FAIL bounce_release: got %0d expected 0", rel_cnt - r0); end
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL bounce_key_down: got %b expected 0", key_down); end
        held_keys = 16'h0200;
        wait_cycles(6*SCAN);
        n_cmp++; if (press_cnt - p0 !== 1) begin n_err++; $display("FAIL bounce_steady_cnt: got %0d expected 1", press_cnt - p0); end
        n_cmp++; if (press_code !== 4'd9) begin n_err++; $display("FAIL bounce_code: got %0d expected 9", press_code); end
        held_keys = '0;
        wait_cycles(6*SCAN);
        n_cmp++; if (rel_cnt - r0 !== 1) begin n_err++; $display("FAIL bounce_release_end: got %0d expected 1", rel_cnt - r0); end
    endtask

    task automatic test_multi();
        int p0, r0;
        p0 = press_cnt; r0 = rel_cnt;
        held_keys = 16'h0021;
        wait_cycles(10*SCAN);
        n_cmp++; if (press_cnt - p0 !== 0) begin n_err++; $display("FAIL multi_press: got %0d expected 0", press_cnt - p0); end
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL multi_key_down: got %b expected 0", key_down); end
        held_keys = 16'h0001;
        wait_cycles(6*SCAN);
        n_cmp++; if (press_cnt - p0 !== 1) begin n_err++; $display("FAIL multi_single_cnt: got %0d expected 1", press_cnt - p0); end
        n_cmp++; if (press_code !== 4'd0) begin n_err++; $display("FAIL multi_code: got %0d expected 0", press_code); end
        held_keys = '0;
        wait_cycles(6*SCAN);
        n_cmp++; if (rel_cnt - r0 !== 1) begin n_err++; $display("FAIL multi_release: got %0d expected 1", rel_cnt - r0); end
    endtask

    task automatic test_rollover();
        int p0, r0, k0;
        p0 = press_cnt; r0 = rel_cnt;
        held_keys = 16'h0008;
        wait_cycles(6*SCAN);
        n_cmp++; if (press_code !== 4'd3) begin n_err++; $display("FAIL roll_first_code: got %0d expected 3", press_code); end
        k0 = kd_low_cnt;
        held_keys = 16'h1000;
        wait_cycles(6*SCAN);
        n_cmp++; if (press_cnt - p0 !== 2) begin n_err++; $display("FAIL roll_press_cnt: got %0d expected 2", press_cnt - p0); end
        n_cmp++; if (press_code !== 4'd12) begin n_err++; $display("FAIL roll_code: got %0d expected 12", press_code); end
        n_cmp++; if (rel_cnt - r0 !== 0) begin n_err++; $display("FAIL roll_release: got %0d expected 0", rel_cnt - r0); end
        n_cmp++; if (kd_low_cnt - k0 !== 0) begin n_err++; $display("FAIL roll_key_down_gap: got %0d low cycles expected 0", kd_low_cnt - k0); end
        held_keys = '0;
        wait_cycles(6*SCAN);
        n_cmp++; if (rel_cnt - r0 !== 1) begin n_err++; $display("FAIL roll_release_end: got %0d expected 1", rel_cnt - r0); end
    endtask

    task automatic test_enable();
        int p0, r0;
        p0 = press_cnt; r0 = rel_cnt;
        enable    = 1'b0;
        held_keys = 16'h0080;
        wait_cycles(6*SCAN);
        n_cmp++; if (press_cnt - p0 !== 0) begin n_err++; $display("FAIL en_gated_press: got %0d expected 0", press_cnt - p0); end
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL en_gated_key_down: got %b expected 0", key_down); end
        enable = 1'b1;
        wait_cycles(SCAN + 2);
        n_cmp++; if (press_cnt - p0 !== 1) begin n_err++; $display("FAIL en_rise_press: got %0d expected 1", press_cnt - p0); end
        n_cmp++; if (press_code !== 4'd7) begin n_err++; $display("FAIL en_rise_code: got %0d expected 7", press_code); end
        enable = 1'b0;
        wait_cycles(2);
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL en_drop_key_down: got %b expected 0", key_down); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL en_drop_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        n_cmp++; if (rel_cnt - r0 !== 0) begin n_err++; $display("FAIL en_drop_release: got %0d expected 0", rel_cnt - r0); end
        enable = 1'b1;
        wait_cycles(SCAN + 2);
        n_cmp++; if (press_cnt - p0 !== 2) begin n_err++; $display("FAIL en_repress: got %0d expected 2", press_cnt - p0); end
        held_keys = '0;
        wait_cycles(6*SCAN);
        n_cmp++; if (rel_cnt - r0 !== 1) begin n_err++; $display("FAIL en_release_end: got %0d expected 1", rel_cnt - r0); end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        p0 = press_cnt;
        held_keys = 16'h8000;
        wait_cycles(6*SCAN);
        n_cmp++; if (press_code !== 4'd15) begin n_err++; $display("FAIL rst_pre_code: got %0d expected 15", press_code); end
        reset = 1'b0;
        #1;
        n_cmp++; if (key_down !== 1'b0) begin n_err++; $display("FAIL rst_mid_key_down: got %b expected 0", key_down); end
        n_cmp++; if (keypad_data !== 4'd0) begin n_err++; $display("FAIL rst_mid_data: got %0d expected 0", keypad_data); end
        wait_cycles(3);
        n_cmp++; if (col_out !== 4'b1110) begin n_err++; $display("FAIL rst_mid_col: got %b expected %b", col_out, 4'b1110); end
        n_cmp++; if (keypad_enable !== 1'b0 || key_release !== 1'b0) begin n_err++; $display("FAIL rst_mid_strobes: got %b%b expected 00", keypad_enable, key_release); end
        reset = 1'b1;
        wait_cycles(6*SCAN);
        n_cmp++; if (press_cnt - p0 !== 2) begin n_err++; $display("FAIL rst_repress_cnt: got %0d expected 2", press_cnt - p0); end
        n_cmp++; if (keypad_data !== 4'd15) begin n_err++; $display("FAIL rst_repress_data: got %0d expected 15", keypad_data); end
        held_keys = '0;
        wait_cycles(6*SCAN);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        enable    = 1'b1;
        held_keys = '0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_rollover();
        test_enable();
        test_reset_mid_press();
        n_cmp++; if (excl_cnt !== 0) begin n_err++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", excl_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low keypad matrix, synchronises and debounces the row returns, and produces the key code, a single-cycle press strobe and a held level consumed by the game controller's keypad inputs. It sits between the board keypad pins and the game logic, supplying the `keypad_data` / `keypad_enable` pair the controller receives. It also emits a release strobe so that downstream LED and piezo feedback can be stopped when the key is lifted.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to commit a state change; range 1–15.
- `clk` input, 1 bit: single system clock.
- `reset` input, 1 bit: reset, asynchronous and active-low.
- `enable` input, 1 bit: when low, strobes are suppressed and the committed state is forced to no-key.
- `row_in` input, 4 bits: keypad rows, active-low with pull-ups; asynchronous to `clk`.
- `col_out` output, 4 bits: column drive, one-cold (exactly one bit low).
- `keypad_data` output, 4 bits: code of the last committed key, `row*4 + col`, range 0–15.
- `keypad_enable` output, 1 bit: one-cycle pulse when a key press is committed.
- `key_down` output, 1 bit: high while a committed key is held.
- `key_release` output, 1 bit: one-cycle pulse when a committed key is released.

## Operation
- **Synchroniser.** `row_in` passes through a 2-flop synchroniser before any use.
- **Column sequence.**
  - The divider counts 0..SCAN_DIV-1 per column slot.
  - Column index cycles 0→1→2→3→0.
  - `col_out` = ~(1 << col).
- **Row sampling.** Rows are sampled on the last cycle of each slot (divider = SCAN_DIV-1). A low row bit r in column c marks key r*4+c as closed.
- **Scan result.** Formed at the column-3 sample and classified as one of:
  - NONE: zero keys closed.
  - KEY(k): exactly one key closed.
  - MULTI: two or more keys closed.
- **Debounce.** Uses a candidate register plus a 4-bit saturating count.
  - Result equals candidate: count increments.
  - Result differs: candidate ← result, count ← 1.
  - MULTI always sets count ← 0 and is never committed.
- **Commit.** Occurs when count reaches DEBOUNCE_SCANS and candidate ≠ committed state, with `enable` high.
  - NONE → KEY(k): `keypad_data` ← k, pulse `keypad_enable`, `key_down` ← 1.
  - KEY(k) → NONE: pulse `key_release`, `key_down` ← 0; `keypad_data` holds k.
  - KEY(k1) → KEY(k2) (roll-over): `keypad_data` ← k2, pulse `keypad_enable`; `key_down` stays 1; no release pulse.
- **Enable low.**
  - The committed state is forced to NONE and `key_down` ← 0, with no release pulse.
  - Scanning and debounce continue.
  - When `enable` rises, a key still held commits as a new press at the next matching scan.
- **Committed state machine.** Two states, IDLE (no key) and HELD(k), with transitions exactly as in the commit rules above.

## Timing
- **Reset values:**
  - `col_out` = 4'b1110.
  - divider, column index, count = 0.
  - candidate = NONE, committed state = IDLE.
  - `keypad_data` = 0, `keypad_enable` = 0, `key_down` = 0, `key_release` = 0.
- **Scan period:** 4·SCAN_DIV cycles. The synchroniser delay (2 cycles) is absorbed because sampling happens at slot end.
- **Strobe timing:** `keypad_enable` / `key_release` go high on the edge after the column-3 sample that satisfies the commit rule, for exactly one cycle. `keypad_data` is valid in that same cycle and holds afterwards.
- **Press latency:** with a clean press starting before a scan's column-0 sample, the strobe arrives DEBOUNCE_SCANS scans later, ±1 scan.
- **Strobe exclusivity:** `keypad_enable` and `key_release` are never high in the same cycle.
- **Reset mid-operation:** asserting reset mid-press drops all outputs to their reset values immediately. After reset deasserts, a still-held key produces a fresh press strobe after debounce.
- **Count wrap:** the count saturates at 15 and never wraps back to a commit.

## Structure
- **Package `keypad_pkg`:**
  - scan-result enum (NONE, KEY, MULTI).
  - committed-state enum (IDLE, HELD).
  - `KEY_ROWS` = 4, `KEY_COLS` = 4.
  - `COL_IDLE` = 4'b1110.
- **Sub-module `keypad_debounce`:** takes scan result, result-valid, and `enable`; contains candidate/count/committed logic and returns code, strobes and `key_down`. Column drive, synchroniser and sampling stay in the top module.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (scan period 16 cycles).
- **Clean press/release:** hold key 6 (row 1 driven low while `col_out`=4'b1011) for 10 scans → one `keypad_enable` pulse with `keypad_data`=6 about 3 scans after press, `key_down`=1. Release → one `key_release` pulse 3 scans later, `key_down`=0, `keypad_data` stays 6.
- **Bounce:** key 9 toggled closed/open every scan for 8 scans → no strobes, `key_down`=0. Then held steadily → a single press of 9.
- **Multi-key:** keys 0 and 5 held together for 10 scans → no strobes. Key 5 released while 0 stays held → press of 0 after 3 scans.
- **Roll-over:** key 3 committed, then switched directly to key 12 → `keypad_enable` pulse with `keypad_data`=12, no `key_release`, `key_down` continuously 1.
- **Enable gating:** `enable`=0 while key 7 is held → no strobe, `key_down`=0. Raise `enable` → press of 7 within 1 scan.
- **Reset mid-press:** while key 15 is held, pulse `reset` low for 3 cycles → all outputs return to reset values and `col_out`=4'b1110. After release of reset, press of 15 after 3 scans.
